// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C bus arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, with wrap.
// Zero latency; no flow control of its own.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic               o_any,
    output logic [PW-1:0]      o_idx
);

    logic [PW-1:0] w_j;

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_j   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = PW'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sequencing one I2C byte transaction at a time, with a WAIT watchdog.
// Grant/start one cycle after REQ; response one cycle after M_DONE; requesters hold REQ until RSP_VALID.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  TIMEOUT_CYC = 1024,
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1),
    localparam int PW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            RW,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] ADDR,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] WDATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [I2C_DATA_W-1:0]         RSP_DATA,
    output logic                          RSP_ERR,
    output logic                          M_START,
    output logic [I2C_ADDR_W-1:0]         M_ADDR,
    output logic                          M_RW,
    output logic [I2C_DATA_W-1:0]         M_WDATA,
    output logic                          M_ABORT,
    input  logic [I2C_DATA_W-1:0]         M_RDATA,
    input  logic                          M_DONE,
    output logic                          BUSY
);

    arb_state_t              r_state, w_state_nxt;
    logic [PW-1:0]           r_ptr, w_ptr_nxt;
    logic [PW-1:0]           r_idx, w_idx_nxt;
    logic [TO_W-1:0]         r_timer, w_timer_nxt;
    logic [NUM_REQ-1:0]      r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]      r_rsp_vld, w_rsp_vld_nxt;
    logic [I2C_DATA_W-1:0]   r_rsp_dat, w_rsp_dat_nxt;
    logic                    r_rsp_err, w_rsp_err_nxt;
    logic                    r_m_start, w_m_start_nxt;
    logic [I2C_ADDR_W-1:0]   r_m_addr, w_m_addr_nxt;
    logic                    r_m_rw, w_m_rw_nxt;
    logic [I2C_DATA_W-1:0]   r_m_wdat, w_m_wdat_nxt;
    logic                    r_m_abort, w_m_abort_nxt;
    logic                    r_busy, w_busy_nxt;

    logic                    w_any;
    logic [PW-1:0]           w_pick;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req (REQ),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_gnt     <= '0;
            r_rsp_vld <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_m_start <= 1'b0;
            r_m_addr  <= '0;
            r_m_rw    <= 1'b0;
            r_m_wdat  <= '0;
            r_m_abort <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_gnt     <= w_gnt_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
            r_rsp_dat <= w_rsp_dat_nxt;
            r_rsp_err <= w_rsp_err_nxt;
            r_m_start <= w_m_start_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_rw    <= w_m_rw_nxt;
            r_m_wdat  <= w_m_wdat_nxt;
            r_m_abort <= w_m_abort_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Pulse-type outputs default low; latched transaction fields default to hold.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        w_gnt_nxt     = r_gnt;
        w_rsp_vld_nxt = '0;
        w_rsp_dat_nxt = '0;
        w_rsp_err_nxt = 1'b0;
        w_m_start_nxt = 1'b0;
        w_m_addr_nxt  = r_m_addr;
        w_m_rw_nxt    = r_m_rw;
        w_m_wdat_nxt  = r_m_wdat;
        w_m_abort_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = ISSUE;
                    w_idx_nxt     = w_pick;
                    w_m_start_nxt = 1'b1;
                    w_gnt_nxt     = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_pick == PW'(i)) begin
                            w_gnt_nxt[i] = 1'b1;
                            w_m_addr_nxt = ADDR[i*I2C_ADDR_W +: I2C_ADDR_W];
                            w_m_rw_nxt   = RW[i];
                            w_m_wdat_nxt = WDATA[i*I2C_DATA_W +: I2C_DATA_W];
                        end
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
                w_timer_nxt = '0;
            end
            WAIT: begin
                // A completion in the watchdog's last cycle still counts as success.
                if (M_DONE) begin
                    w_state_nxt   = RESP;
                    w_rsp_vld_nxt = r_gnt;
                    w_rsp_dat_nxt = r_m_rw ? M_RDATA : '0;
                end else if (r_timer == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt   = RESP;
                    w_rsp_vld_nxt = r_gnt;
                    w_rsp_err_nxt = 1'b1;
                    w_m_abort_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_ptr_nxt   = (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign GNT       = r_gnt;
    assign RSP_VALID = r_rsp_vld;
    assign RSP_DATA  = r_rsp_dat;
    assign RSP_ERR   = r_rsp_err;
    assign M_START   = r_m_start;
    assign M_ADDR    = r_m_addr;
    assign M_RW      = r_m_rw;
    assign M_WDATA   = r_m_wdat;
    assign M_ABORT   = r_m_abort;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: two instances (long and short watchdog) share one stimulus stream,
// each checked every cycle against a transaction-level model plus directed literal checks.
module tb_i2c_bus_arbiter;
    localparam int N    = 4;
    localparam int TO_A = 1024;
    localparam int TO_B = 8;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   REQ = '0;
    logic [N-1:0]   RW = '0;
    logic [7*N-1:0] ADDR = '0;
    logic [8*N-1:0] WDATA = '0;
    logic [7:0]     M_RDATA = '0;
    logic           M_DONE = 1'b0;

    logic [N-1:0] gnt [2];
    logic [N-1:0] rspv [2];
    logic [7:0]   rspd [2];
    logic         rspe [2];
    logic         mst [2];
    logic [6:0]   madr [2];
    logic         mrw [2];
    logic [7:0]   mwd [2];
    logic         mab [2];
    logic         busy [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO_A)) u_dut_a (
        .CLK(CLK), .RST(RST), .REQ(REQ), .RW(RW), .ADDR(ADDR), .WDATA(WDATA),
        .GNT(gnt[0]), .RSP_VALID(rspv[0]), .RSP_DATA(rspd[0]), .RSP_ERR(rspe[0]),
        .M_START(mst[0]), .M_ADDR(madr[0]), .M_RW(mrw[0]), .M_WDATA(mwd[0]),
        .M_ABORT(mab[0]), .M_RDATA(M_RDATA), .M_DONE(M_DONE), .BUSY(busy[0])
    );

    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO_B)) u_dut_b (
        .CLK(CLK), .RST(RST), .REQ(REQ), .RW(RW), .ADDR(ADDR), .WDATA(WDATA),
        .GNT(gnt[1]), .RSP_VALID(rspv[1]), .RSP_DATA(rspd[1]), .RSP_ERR(rspe[1]),
        .M_START(mst[1]), .M_ADDR(madr[1]), .M_RW(mrw[1]), .M_WDATA(mwd[1]),
        .M_ABORT(mab[1]), .M_RDATA(M_RDATA), .M_DONE(M_DONE), .BUSY(busy[1])
    );

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: actual=0x%0h required=0x%0h", nm, u, act, exp);
        end
    endtask

    // Transaction-level model: owner (-1 = none), waited = WAIT cycles elapsed (-1 = start cycle).
    int         own [2] = '{-1, -1};
    int         waited [2] = '{0, 0};
    int         ptr [2] = '{0, 0};
    bit         resp [2] = '{0, 0};
    bit         err [2] = '{0, 0};
    logic [7:0] dat [2];
    logic [6:0] la [2];
    logic       lrw [2];
    logic [7:0] lwd [2];
    int         j;

    always @(posedge CLK) begin
        for (int u = 0; u < 2; u++) begin
            if (RST) begin
                own[u] = -1; resp[u] = 0; err[u] = 0; ptr[u] = 0;
            end else if (own[u] >= 0 && resp[u]) begin
                ptr[u] = (own[u] + 1) % N;
                own[u] = -1; resp[u] = 0;
            end else if (own[u] >= 0) begin
                if (waited[u] < 0) waited[u] = 0;
                else if (M_DONE) begin
                    resp[u] = 1; err[u] = 0; dat[u] = lrw[u] ? M_RDATA : 8'h00;
                end else if (waited[u] == ((u == 0) ? TO_A : TO_B) - 1) begin
                    resp[u] = 1; err[u] = 1; dat[u] = 8'h00;
                end else waited[u] = waited[u] + 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr[u] + k) % N;
                    if (own[u] < 0 && REQ[j]) begin
                        own[u] = j; waited[u] = -1;
                        la[u] = ADDR[7*j +: 7]; lrw[u] = RW[j]; lwd[u] = WDATA[8*j +: 8];
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    logic [N-1:0] e_gnt;
    always @(negedge CLK) begin
        for (int u = 0; u < 2; u++) begin
            e_gnt = (own[u] >= 0) ? N'(1 << own[u]) : '0;
            chk("gnt", u, 32'(gnt[u]), 32'(e_gnt));
            chk("m_start", u, 32'(mst[u]), 32'(own[u] >= 0 && !resp[u] && waited[u] < 0));
            chk("rsp_valid", u, 32'(rspv[u]), resp[u] ? 32'(e_gnt) : 32'd0);
            chk("rsp_data", u, 32'(rspd[u]), resp[u] ? 32'(dat[u]) : 32'd0);
            chk("rsp_err", u, 32'(rspe[u]), 32'(resp[u] && err[u]));
            chk("m_abort", u, 32'(mab[u]), 32'(resp[u] && err[u]));
            chk("busy", u, 32'(busy[u]), 32'(own[u] >= 0));
            if (own[u] >= 0) begin
                chk("m_addr", u, 32'(madr[u]), 32'(la[u]));
                chk("m_rw", u, 32'(mrw[u]), 32'(lrw[u]));
                chk("m_wdata", u, 32'(mwd[u]), 32'(lwd[u]));
            end
        end
    end

    task automatic chk_zero(input string nm, input int u);
        chk({nm, "_gnt"}, u, 32'(gnt[u]), 0);
        chk({nm, "_rspv"}, u, 32'(rspv[u]), 0);
        chk({nm, "_rspd"}, u, 32'(rspd[u]), 0);
        chk({nm, "_rspe"}, u, 32'(rspe[u]), 0);
        chk({nm, "_start"}, u, 32'(mst[u]), 0);
        chk({nm, "_addr"}, u, 32'(madr[u]), 0);
        chk({nm, "_rw"}, u, 32'(mrw[u]), 0);
        chk({nm, "_wdata"}, u, 32'(mwd[u]), 0);
        chk({nm, "_abort"}, u, 32'(mab[u]), 0);
        chk({nm, "_busy"}, u, 32'(busy[u]), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; REQ = '0; M_DONE = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_on(input int u, input bit want_rsp, input string nm);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge CLK);
            if (want_rsp ? (rspv[u] != '0) : mst[u]) ok = 1;
        end
        chk(nm, u, 32'(ok), 1);
    endtask

    int t;
    int last_rsp;
    logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        repeat (2) @(negedge CLK);
        chk_zero("reset", 0);
        chk_zero("reset", 1);

        // Single write, completion sampled 10 edges after the grant edge
        do_reset();
        ADDR[6:0] = 7'h50; WDATA[7:0] = 8'hA5; RW[0] = 1'b0; REQ = 4'b0001;
        @(negedge CLK);
        t = cyc;
        chk("t1_gnt", 0, 32'(gnt[0]), 32'h1);
        chk("t1_start", 0, 32'(mst[0]), 1);
        chk("t1_addr", 0, 32'(madr[0]), 32'h50);
        chk("t1_wdata", 0, 32'(mwd[0]), 32'hA5);
        repeat (9) @(negedge CLK);
        M_RDATA = 8'h77; M_DONE = 1'b1;
        @(negedge CLK);
        M_DONE = 1'b0;
        chk("t1_rspv", 0, 32'(rspv[0]), 32'h1);
        chk("t1_rspd", 0, 32'(rspd[0]), 0);
        chk("t1_rspe", 0, 32'(rspe[0]), 0);
        chk("t1_lat", 0, cyc - t, 10);
        REQ = '0;
        @(negedge CLK);
        chk("t1_gnt_clr", 0, 32'(gnt[0]), 0);

        // Read from requester 2, with a stray M_DONE while idle first
        do_reset();
        M_DONE = 1'b1;
        @(negedge CLK);
        M_DONE = 1'b0;
        RW[2] = 1'b1; ADDR[20:14] = 7'h1C; REQ = 4'b0100;
        @(negedge CLK);
        chk("t2_gnt", 0, 32'(gnt[0]), 32'h4);
        chk("t2_addr", 0, 32'(madr[0]), 32'h1C);
        chk("t2_rw", 0, 32'(mrw[0]), 1);
        repeat (2) @(negedge CLK);
        M_RDATA = 8'h3E; M_DONE = 1'b1;
        @(negedge CLK);
        M_DONE = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk("t2_rspv", u, 32'(rspv[u]), 32'h4);
            chk("t2_rspd", u, 32'(rspd[u]), 32'h3E);
            chk("t2_rspe", u, 32'(rspe[u]), 0);
        end
        REQ = '0;

        // Round-robin with all requesters held
        do_reset();
        RW = '0; REQ = 4'b1111;
        last_rsp = -1;
        for (int i = 0; i < 5; i++) begin
            wait_on(0, 1'b0, "t3_start_seen");
            chk("t3_order", 0, 32'(gnt[0]), 32'(rr_exp[i]));
            if (i > 0) chk("t3_gap", 0, cyc - last_rsp, 2);
            @(negedge CLK);
            M_DONE = 1'b1;
            @(negedge CLK);
            M_DONE = 1'b0;
            chk("t3_rspv", 0, 32'(rspv[0]), 32'(rr_exp[i]));
            last_rsp = cyc;
        end
        REQ = '0;

        // Timeout on the short-watchdog instance; input changes after grant are ignored
        do_reset();
        ADDR[13:7] = 7'h2A; WDATA[15:8] = 8'h11; RW[1] = 1'b0; REQ = 4'b0010;
        @(negedge CLK);
        t = cyc;
        chk("t4_gnt", 1, 32'(gnt[1]), 32'h2);
        REQ = '0; ADDR[13:7] = 7'h55; WDATA[15:8] = 8'hEE;
        wait_on(1, 1'b1, "t4_rsp_seen");
        chk("t4_lat", 1, cyc - t, 9);
        chk("t4_abort", 1, 32'(mab[1]), 1);
        chk("t4_rspv", 1, 32'(rspv[1]), 32'h2);
        chk("t4_rspe", 1, 32'(rspe[1]), 1);
        chk("t4_rspd", 1, 32'(rspd[1]), 0);
        chk("t4_addr", 1, 32'(madr[1]), 32'h2A);
        @(negedge CLK);
        chk("t4_abort_end", 1, 32'(mab[1]), 0);
        chk("t4_rspv_end", 1, 32'(rspv[1]), 0);

        // M_DONE in the same cycle as the watchdog expiry
        do_reset();
        RW[0] = 1'b1; REQ = 4'b0001; M_RDATA = 8'h5A;
        @(negedge CLK);
        repeat (8) @(negedge CLK);
        M_DONE = 1'b1;
        @(negedge CLK);
        M_DONE = 1'b0; REQ = '0;
        for (int u = 0; u < 2; u++) begin
            chk("t5_rspv", u, 32'(rspv[u]), 32'h1);
            chk("t5_rspe", u, 32'(rspe[u]), 0);
            chk("t5_rspd", u, 32'(rspd[u]), 32'h5A);
            chk("t5_abort", u, 32'(mab[u]), 0);
        end

        // Reset during WAIT discards the transaction
        repeat (2) @(negedge CLK);
        REQ = 4'b0010;
        @(negedge CLK);
        repeat (3) @(negedge CLK);
        RST = 1'b1; REQ = '0;
        @(negedge CLK);
        chk_zero("t5_rst", 0);
        chk_zero("t5_rst", 1);
        RST = 1'b0; REQ = 4'b1000;
        @(negedge CLK);
        chk("t5_gnt3", 0, 32'(gnt[0]), 32'h8);
        chk("t5_gnt3", 1, 32'(gnt[1]), 32'h8);
        @(negedge CLK);
        M_DONE = 1'b1;
        @(negedge CLK);
        M_DONE = 1'b0; REQ = '0;
        chk("t5_rspv3", 0, 32'(rspv[0]), 32'h8);
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, errors=%0d", errors);
        $fatal(1);
    end

endmodule
